// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: single-issue command/operand stage in front of a 4-bit ALU.
// It accepts register-addressed commands, reads operands from an internal
// register file, drives the ALU inputs for one cycle, captures the result and
// flags, writes the result back and returns a response over valid/ready.
// Optional feature macro: ALU_SEQ_OVF_EN adds the rsp_ovf output (signed overflow
// for ADD/SUB).
module alu_op_sequencer #(
    parameter int unsigned  DATA_W   = 4,
    parameter int unsigned  NUM_REGS = 4,
    localparam int unsigned RW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [RW-1:0]     cmd_dst,
    input  logic [RW-1:0]     cmd_srca,
    input  logic [RW-1:0]     cmd_srcb,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
`ifdef ALU_SEQ_OVF_EN
    output logic              rsp_ovf,
`endif
    input  logic [RW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned MSB      = DATA_W - 1;
    localparam logic [2:0]  OP_ADD   = 3'b000;
    localparam logic [2:0]  OP_SUB   = 3'b001;
    localparam logic [2:0]  OP_LOAD  = 3'b110;
    localparam logic [2:0]  OP_NOP   = 3'b111;
    localparam logic [2:0]  SEL_IDLE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [RW-1:0]       dst_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   opa_q;
    logic [DATA_W-1:0]   opb_q;
    logic [2:0]          sel_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_carry_q;
    logic                rsp_zero_q;

    logic                accept_c;
    logic                exec_c;
    logic                rsp_done_c;
    logic [DATA_W-1:0]   cap_data_c;
    logic                cap_carry_c;
    logic                cap_zero_c;
    logic                wr_en_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded controls; cmd_ready is a pure decode of the state register
    always_comb begin
        cmd_ready  = 1'b0;
        accept_c   = 1'b0;
        exec_c     = 1'b0;
        rsp_done_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                accept_c  = cmd_valid;
            end
            S_EXEC:  exec_c     = 1'b1;
            S_RESP:  rsp_done_c = rsp_ready;
            default: ;
        endcase
    end

    // Result selection at the end of EXEC: ALU result, immediate, or NOP constant
    always_comb begin
        cap_data_c  = alu_out;
        cap_carry_c = alu_carry;
        cap_zero_c  = alu_zero;
        wr_en_c     = exec_c;
        case (op_q)
            OP_LOAD: begin
                cap_data_c  = imm_q;
                cap_carry_c = 1'b0;
                cap_zero_c  = (imm_q == '0);
            end
            OP_NOP: begin
                cap_data_c  = '0;
                cap_carry_c = 1'b0;
                cap_zero_c  = 1'b1;
                wr_en_c     = 1'b0;
            end
            default: ;
        endcase
    end

    // Command/operand latches; ALU select is live only during the EXEC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= OP_NOP;
            dst_q <= '0;
            imm_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            sel_q <= SEL_IDLE;
        end else if (accept_c) begin
            op_q  <= cmd_op;
            dst_q <= cmd_dst;
            imm_q <= cmd_imm;
            opa_q <= regs_q[cmd_srca];
            opb_q <= regs_q[cmd_srcb];
            sel_q <= (cmd_op == OP_LOAD) ? SEL_IDLE : cmd_op;
        end else begin
            sel_q <= SEL_IDLE;
        end
    end

    // Register file with write-back at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs_q[dst_q] <= cap_data_c;
        end
    end

    // Response registers: load in EXEC, hold until the consumer takes them
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else if (exec_c) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cap_data_c;
            rsp_carry_q <= cap_carry_c;
            rsp_zero_q  <= cap_zero_c;
        end else if (rsp_done_c) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef ALU_SEQ_OVF_EN
    logic ovf_c;
    logic rsp_ovf_q;

    // Two's-complement overflow for ADD/SUB from operand and result sign bits
    always_comb begin
        ovf_c = 1'b0;
        case (op_q)
            OP_ADD:  ovf_c = (opa_q[MSB] == opb_q[MSB]) && (alu_out[MSB] != opa_q[MSB]);
            OP_SUB:  ovf_c = (opa_q[MSB] != opb_q[MSB]) && (alu_out[MSB] != opa_q[MSB]);
            default: ovf_c = 1'b0;
        endcase
    end

    // Overflow flag captured alongside the other response fields
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_ovf_q <= 1'b0;
        end else if (exec_c) begin
            rsp_ovf_q <= ovf_c;
        end
    end

    assign rsp_ovf = rsp_ovf_q;
`endif

    assign alu_a     = opa_q;
    assign alu_b     = opb_q;
    assign alu_sel   = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign dbg_data  = regs_q[dbg_addr];

endmodule
